pwm_capture: RTL



---
 rtl/pwm_capture.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input in
// clk cycles, strobes each complete measurement and flags a stuck input.
// Optional glitch filter: define PWM_CAPTURE_FILTER_EN to insert a
// FILTER_LEN-deep majority-free persistence filter after the synchroniser.
module pwm_capture #(
  parameter int unsigned W          = 16,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm_in,
  output logic [W-1:0] high_time,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         timeout,
  output logic         level
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } state_t;

  // Counter value one below saturation: an edge arriving now still measures
  // 2^W-1, no edge now means the measurement can no longer complete.
  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_LAST = {{(W-1){1'b1}}, 1'b0};

  logic sync1_q;
  logic sync2_q;
  logic s;
  logic p_q;
  logic rise;
  logic fall;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] hi_tmp_q, hi_tmp_d;
  logic [W-1:0] high_time_q, high_time_d;
  logic [W-1:0] period_q, period_d;
  logic         valid_q, valid_d;
  logic         timeout_q, timeout_d;
  logic         stuck;

  // Two-flop synchroniser bringing pwm_in into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int unsigned FCW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           filt_q, filt_d;

  // Filter output follows the synchronised level only once it has differed
  // for FILTER_LEN consecutive samples; any agreeing sample restarts the run.
  always_comb begin
    fcnt_d = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
      filt_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      filt_q <= filt_d;
    end
  end

  assign s = filt_q;
`else
  localparam int unsigned FILTER_LEN_UNUSED = FILTER_LEN;

  assign s = sync2_q;
`endif

  // Previous conditioned level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= 1'b0;
    end else begin
      p_q <= s;
    end
  end

  assign rise  = s & ~p_q;
  assign fall  = ~s & p_q;
  assign stuck = (cnt_q == CNT_LAST) && !rise && !fall;

  // Next-state logic: counter, measurement FSM and output registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    hi_tmp_d    = hi_tmp_q;
    high_time_d = high_time_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    // Every rising edge restarts the count so cnt+1 is the distance to it.
    if (rise) begin
      cnt_d = '0;
    end

    case (state_q)
      // A high level at reset release looks like a rise; wait for a real fall.
      S_IDLE: begin
        if (fall) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (rise) begin
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (fall) begin
          hi_tmp_d = cnt_q + 1'b1;
          state_d  = S_LOW;
        end else if (stuck) begin
          timeout_d = 1'b1;
          state_d   = s ? S_IDLE : S_ARM;
        end
      end
      S_LOW: begin
        if (rise) begin
          high_time_d = hi_tmp_q;
          period_d    = cnt_q + 1'b1;
          valid_d     = 1'b1;
          timeout_d   = 1'b0;
          state_d     = S_HIGH;
        end else if (stuck) begin
          timeout_d = 1'b1;
          state_d   = s ? S_IDLE : S_ARM;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hi_tmp_q    <= '0;
      high_time_q <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_tmp_q    <= hi_tmp_d;
      high_time_q <= high_time_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign high_time = high_time_q;
  assign period    = period_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign level     = s;

endmodule
